pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 43 ++++
 rtl/pipeline_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if - hazard/memory status and stage-control bundle
//
// Carries the signals exchanged between the pipeline datapath and
// pipeline_ctrl.
//   slave  : controller side (hazard/memory status in, enables/flushes out)
//   master : datapath side (drives status, receives enables/flushes)
// Signals:
//   load_use_flag, branch_taken, dmem_req, dmem_ready : datapath status
//   pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we   : register write enables
//   if_id_flush, id_ex_flush, mem_wb_bubble           : NOP insertion
//   mem_fault                                         : sticky memory timeout
//   stall_cnt, flush_cnt                              : performance counters
interface pipeline_ctrl_if;
    logic        load_use_flag;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_we;
    logic        if_id_we;
    logic        id_ex_we;
    logic        ex_mem_we;
    logic        mem_wb_we;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_bubble;
    logic        mem_fault;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport slave (
        input  load_use_flag, branch_taken, dmem_req, dmem_ready,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault,
               stall_cnt, flush_cnt
    );

    modport master (
        output load_use_flag, branch_taken, dmem_req, dmem_ready,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl - stall/flush/freeze controller for a 5-stage pipeline
//
// Ports:
//   clk   : single clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : pipeline_ctrl_if.slave (hazard status in, stage controls out)
// Parameter:
//   MEM_TIMEOUT : max MEM_WAIT cycles before a data-memory fault (2..255)
// Build option:
//   PIPE_PERF_CNT_EN : when defined, stall_cnt/flush_cnt are saturating
//                      counters; otherwise both are tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; branch flush / load-use stall decoded here
// MEM_WAIT | data memory busy, whole pipeline frozen, waitCnt counting
// FAULT    | memory timed out; pipeline frozen until reset
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state, nextState, decodeState;
    logic [7:0] waitCnt, waitCntNext;

    logic pcWe, ifIdWe, idExWe, exMemWe, memWbWe;
    logic ifIdFlush, idExFlush, memWbBubble, memFault;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= waitCntNext;
        end
    end

    // Outputs follow RUN decode while reset is held, whatever the
    // registered state, so the datapath sees a sane pipeline in reset.
    assign decodeState = rst_n ? state : RUN;

    always_comb begin
        nextState   = state;
        waitCntNext = waitCnt;
        pcWe        = 1'b1;
        ifIdWe      = 1'b1;
        idExWe      = 1'b1;
        exMemWe     = 1'b1;
        memWbWe     = 1'b1;
        ifIdFlush   = 1'b0;
        idExFlush   = 1'b0;
        memWbBubble = 1'b0;
        memFault    = 1'b0;

        unique case (decodeState)
            RUN, MEM_WAIT: begin
                // Freeze when memory is outstanding: a new unready request
                // in RUN, or any not-ready cycle in MEM_WAIT (dmem_req is
                // assumed held by the MEM stage while waiting).
                if ((decodeState == RUN && bus.dmem_req && !bus.dmem_ready) ||
                    (decodeState == MEM_WAIT && !bus.dmem_ready)) begin
                    pcWe        = 1'b0;
                    ifIdWe      = 1'b0;
                    idExWe      = 1'b0;
                    exMemWe     = 1'b0;
                    memWbWe     = 1'b0;
                    memWbBubble = 1'b1;
                    if (decodeState == RUN) begin
                        nextState   = MEM_WAIT;
                        waitCntNext = 8'd1;
                    end else if (waitCnt == TIMEOUT) begin
                        nextState = FAULT;
                    end else begin
                        waitCntNext = waitCnt + 8'd1;
                    end
                end else begin
                    nextState   = RUN;
                    waitCntNext = '0;
                    // The branch squashes the instruction that caused the
                    // load-use hazard, so it wins over the stall.
                    if (bus.branch_taken) begin
                        ifIdFlush = 1'b1;
                        idExFlush = 1'b1;
                    end else if (bus.load_use_flag) begin
                        pcWe      = 1'b0;
                        ifIdWe    = 1'b0;
                        idExFlush = 1'b1;
                    end
                end
            end
            FAULT: begin
                pcWe        = 1'b0;
                ifIdWe      = 1'b0;
                idExWe      = 1'b0;
                exMemWe     = 1'b0;
                memWbWe     = 1'b0;
                memWbBubble = 1'b1;
                memFault    = 1'b1;
            end
            default: begin
                nextState   = RUN;
                waitCntNext = '0;
            end
        endcase
    end

    assign bus.pc_we         = pcWe;
    assign bus.if_id_we      = ifIdWe;
    assign bus.id_ex_we      = idExWe;
    assign bus.ex_mem_we     = exMemWe;
    assign bus.mem_wb_we     = memWbWe;
    assign bus.if_id_flush   = ifIdFlush;
    assign bus.id_ex_flush   = idExFlush;
    assign bus.mem_wb_bubble = memWbBubble;
    assign bus.mem_fault     = memFault;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stallCnt, flushCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (!pcWe && stallCnt != 16'hFFFF) begin
                stallCnt <= stallCnt + 16'd1;
            end
            if (ifIdFlush && flushCnt != 16'hFFFF) begin
                flushCnt <= flushCnt + 16'd1;
            end
        end
    end

    assign bus.stall_cnt = stallCnt;
    assign bus.flush_cnt = flushCnt;
`else
    assign bus.stall_cnt = 16'd0;
    assign bus.flush_cnt = 16'd0;
`endif
endmodule
